// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
//   XLEN / ILEN : address and instruction widths
//   slot_t      : one queue entry {filled, pc, instr}
//   NOP         : canonical bubble instruction for downstream stages
//   cnt_width() : width of an occupancy counter for a given queue depth
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic            filled;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } slot_t;

    // Occupancy ranges 0..DEPTH, so one bit more than the pointer width.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// In-order ring of fetch slots.
//   clk, rst            : clock, synchronous active-high reset
//   clear               : drop every slot at the edge (overrides all else)
//   reserve, reserve_pc : claim the tail slot for a granted fetch
//   fill, fill_data     : write the oldest reserved-but-unfilled slot
//   pop                 : retire the head slot
//   head_c              : head slot contents (filled=0 when nothing to deliver)
//   occupancy           : reserved + filled slots
//   unfilled            : reserved slots still waiting for data
module fetch_slot_ring
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     reserve,
    input  logic [XLEN-1:0]          reserve_pc,
    input  logic                     fill,
    input  logic [ILEN-1:0]          fill_data,
    input  logic                     pop,
    output slot_t                    head_c,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   unfilled
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    slot_t          slots [DEPTH];
    logic [AW-1:0]  head_ptr;
    logic [AW-1:0]  tail_ptr;
    logic [AW-1:0]  fill_ptr;

    // Popped slots have filled cleared, so an empty ring always shows filled=0 at the head.
    assign head_c = slots[head_ptr];

    // Pointer and slot update; reserve/fill/pop never touch the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else begin
            if (reserve) begin
                slots[tail_ptr] <= slot_t'{filled: 1'b0, pc: reserve_pc, instr: '0};
                tail_ptr        <= tail_ptr + AW'(1);
            end
            if (fill) begin
                slots[fill_ptr].filled <= 1'b1;
                slots[fill_ptr].instr  <= fill_data;
                fill_ptr               <= fill_ptr + AW'(1);
            end
            if (pop) begin
                slots[head_ptr].filled <= 1'b0;
                head_ptr               <= head_ptr + AW'(1);
            end
            occupancy <= occupancy + CW'(reserve) - CW'(pop);
            unfilled  <= unfilled + CW'(reserve) - CW'(fill);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage between the PC generator and decode.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   pc, pc_four      : current PC in, sequential next PC out (pc+4 on grant, else pc)
//   i_flush          : redirect; drops queued and in-flight fetches
//   imem_req/addr    : fetch request and address (address is pc)
//   imem_gnt         : request accepted
//   imem_rvalid/rdata: in-order instruction response
//   o_valid/o_pc/o_instr, i_ready : head instruction handshake to decode
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_four,
    input  logic            i_flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr,
    input  logic            i_ready
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned OW = 8;

    slot_t          head;
    logic [CW-1:0]  occupancy;
    logic [CW-1:0]  unfilled;
    logic           accept;
    logic           drop;
    logic           fill;
    logic           pop;
    logic           retire_on_flush;

    // outstanding counts every fetch still owed by memory, including the ones
    // already marked for discard; discard is the prefix of those to be dropped.
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  discard;

    // Request depends only on registered occupancy, reset and flush.
    assign imem_req  = ~i_rst & ~i_flush & (occupancy < CW'(DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req & imem_gnt;
    assign pc_four   = accept ? pc + XLEN'(4) : pc;

    // Response routing: older discarded fetches return first.
    assign drop = imem_rvalid & (discard != '0);
    assign fill = imem_rvalid & (discard == '0) & (unfilled != '0) & ~i_flush;

    assign o_valid = head.filled;
    assign pop     = o_valid & i_ready & ~i_flush;
    assign o_pc    = o_valid ? head.pc    : '0;
    assign o_instr = o_valid ? head.instr : '0;

    assign retire_on_flush = imem_rvalid & (outstanding != '0);

    fetch_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (i_flush),
        .reserve    (accept),
        .reserve_pc (pc),
        .fill       (fill),
        .fill_data  (imem_rdata),
        .pop        (pop),
        .head_c     (head),
        .occupancy  (occupancy),
        .unfilled   (unfilled)
    );

    // In-flight bookkeeping; on flush everything still owed becomes discard,
    // less a response arriving in the flush cycle itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else if (i_flush) begin
            outstanding <= outstanding - OW'(retire_on_flush);
            discard     <= outstanding - OW'(retire_on_flush);
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(drop | fill);
            discard     <= discard - OW'(drop);
        end
    end

    // A response with nothing waiting for it is ignored by the datapath.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && imem_rvalid) begin
            assert (discard != '0 || unfilled != '0)
                else $error("fetch_queue: imem_rvalid with no pending fetch");
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-configurable in-order memory and a
// PC generator drive the DUT; accepted fetches push the expected {pc, instr}
// onto a scoreboard that a separate monitor pops on every decode handshake.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        i_flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        i_ready;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t       memq [$];
    exp_t        expq [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] target = 32'h0;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .pc          (pc),
        .pc_four     (pc_four),
        .i_flush     (i_flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .o_valid     (o_valid),
        .o_pc        (o_pc),
        .o_instr     (o_instr),
        .i_ready     (i_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
        end
    endtask

    // Close the current cycle: sample at negedge, then after the posedge update
    // memory, scoreboard and PC generator for the next cycle.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        logic [31:0] pcf;
        logic        fl;
        logic        rs;
        int          cur;
        mreq_t       m;
        @(negedge i_clk);
        acc = imem_req & imem_gnt;
        a   = imem_addr;
        pcf = pc_four;
        fl  = i_flush;
        rs  = i_rst;
        @(posedge i_clk);
        #1;
        cur = cyc;
        cyc++;
        if (rs) begin
            memq.delete();
            expq.delete();
        end else begin
            if (acc) begin
                memq.push_back('{addr: a, due: cur + lat});
                expq.push_back('{pc: a, instr: mk_instr(a)});
            end
            if (fl) expq.delete();
        end
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            m           = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mk_instr(m.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        pc = (fl && !rs) ? target : pcf;
    endtask

    task automatic do_reset(input logic [31:0] start_pc, input int l);
        i_rst    = 1'b1;
        i_flush  = 1'b0;
        imem_gnt = 1'b1;
        i_ready  = 1'b0;
        lat      = l;
        #2;
        chk("req_in_reset", 32'(imem_req), 32'h0);
        step();
        step();
        i_rst = 1'b0;
        pc    = start_pc;
    endtask

    // Scoreboard monitor: every decode handshake must match the oldest expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got pc 0x%08h want no instruction", o_pc);
                end else begin
                    e = expq.pop_front();
                    chk("pop_pc", o_pc, e.pc);
                    chk("pop_instr", o_instr, e.instr);
                end
            end else if (!o_valid) begin
                chk("idle_pc", o_pc, 32'h0);
                chk("idle_instr", o_instr, 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        logic found;
        i_rst = 1'b1; pc = 32'h0; i_flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; i_ready = 1'b0;

        // 1: streaming with 1-cycle memory
        do_reset(32'h0, 1);
        imem_gnt = 1'b1; i_ready = 1'b1;
        #2;
        chk("t1_rst_valid", 32'(o_valid), 32'h0);
        chk("t1_rst_pc", o_pc, 32'h0);
        chk("t1_rst_instr", o_instr, 32'h0);
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_pc4", pc_four, 32'h4);
        step(); #2;
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_valid_t1", 32'(o_valid), 32'h0);
        step(); #2;
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_valid_t2", 32'(o_valid), 32'h1);
        chk("t1_first_pc", o_pc, 32'h0);
        chk("t1_first_instr", o_instr, 32'h1357_0013);
        repeat (8) step();
        imem_gnt = 1'b0;
        repeat (4) step();
        chk("t1_drained", 32'(expq.size()), 32'h0);

        // 2: fill to DEPTH with decode stalled, then drain
        do_reset(32'h0, 1);
        imem_gnt = 1'b1; i_ready = 1'b0;
        repeat (6) step();
        #2;
        chk("t2_full_req", 32'(imem_req), 32'h0);
        chk("t2_full_pc", pc, 32'h10);
        chk("t2_full_pc4", pc_four, 32'h10);
        chk("t2_full_head", o_pc, 32'h0);
        i_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(); #2;
            if (imem_req) found = 1'b1;
        end
        chk("t2_resume_req", 32'(found), 32'h1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        repeat (6) step();
        imem_gnt = 1'b0;
        repeat (6) step();
        chk("t2_drained", 32'(expq.size()), 32'h0);

        // 3: flush with two fetches in flight, 3-cycle memory
        do_reset(32'h0, 3);
        imem_gnt = 1'b1; i_ready = 1'b1;
        step(); step();
        imem_gnt = 1'b0; i_flush = 1'b1; target = 32'h100;
        #2;
        chk("t3_req_flush", 32'(imem_req), 32'h0);
        step();
        i_flush = 1'b0; imem_gnt = 1'b1;
        #2;
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_valid_a3", 32'(o_valid), 32'h0);
        step();
        imem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t3_valid_hold", 32'(o_valid), 32'h0);
            step();
        end
        #2;
        chk("t3_first_valid", 32'(o_valid), 32'h1);
        chk("t3_first_pc", o_pc, 32'h100);
        repeat (3) step();
        chk("t3_drained", 32'(expq.size()), 32'h0);

        // 4: flush coinciding with a response and a pop, 2-cycle memory
        do_reset(32'h0, 2);
        imem_gnt = 1'b1; i_ready = 1'b1;
        repeat (8) step();
        i_flush = 1'b1; target = 32'h200;
        #2;
        chk("t4_pre_valid", 32'(o_valid), 32'h1);
        chk("t4_req_flush", 32'(imem_req), 32'h0);
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t4_valid_hold", 32'(o_valid), 32'h0);
            step();
        end
        #2;
        chk("t4_first_valid", 32'(o_valid), 32'h1);
        chk("t4_first_pc", o_pc, 32'h200);
        imem_gnt = 1'b0;
        repeat (6) step();
        chk("t4_drained", 32'(expq.size()), 32'h0);

        // 5: grant withheld for five cycles
        do_reset(32'h40, 1);
        imem_gnt = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t5_req", 32'(imem_req), 32'h1);
            chk("t5_addr", imem_addr, 32'h40);
            chk("t5_pc4", pc_four, 32'h40);
            step();
        end
        imem_gnt = 1'b1;
        #2;
        chk("t5_grant_pc4", pc_four, 32'h44);
        step();
        imem_gnt = 1'b0;
        #2;
        chk("t5_after_addr", imem_addr, 32'h44);
        chk("t5_after_pc4", pc_four, 32'h44);
        repeat (3) step();
        chk("t5_drained", 32'(expq.size()), 32'h0);

        // 6: reset mid-stream with three slots occupied, then PC wrap
        do_reset(32'h0, 1);
        imem_gnt = 1'b1; i_ready = 1'b0;
        repeat (3) step();
        imem_gnt = 1'b0;
        repeat (2) step();
        #2;
        chk("t6_pre_valid", 32'(o_valid), 32'h1);
        i_rst = 1'b1; imem_gnt = 1'b1;
        #1;
        chk("t6_req_rst", 32'(imem_req), 32'h0);
        step();
        i_rst = 1'b0; pc = 32'hFFFF_FFFC;
        #2;
        chk("t6_valid", 32'(o_valid), 32'h0);
        chk("t6_pc", o_pc, 32'h0);
        chk("t6_req", 32'(imem_req), 32'h1);
        chk("t6_wrap_pc4", pc_four, 32'h0);
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (imem_req) n_acc++;
            step(); #2;
        end
        chk("t6_accepts", 32'(n_acc), 32'h4);
        imem_gnt = 1'b0; i_ready = 1'b1;
        repeat (8) step();
        chk("t6_drained", 32'(expq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
